multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle MIPS control unit. It replaces the single-cycle decoder with a Moore state machine that sequences each instruction over 3–5 cycles and drives the shared-ALU / shared-memory datapath. It supports R-type, addi, slti, lw, sw, beq, bne and j. It can optionally stall on a memory-ready handshake, and it reports illegal opcodes and a retired-instruction count. It sits between the instruction register (opcode source) and the multi-cycle datapath muxes and enables.

## Interface
- OP_WIDTH, 6, opcode width; opcode constants are compared in the low 6 bits.
- CNT_WIDTH, 16, width of the retired-instruction counter.
- USE_MEM_READY, 1, 1 = honour memReady; 0 = treat memReady as constant 1 (no wait states).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  OP_WIDTH  opcode field from the instruction register.
- memReady  in  1  memory completed the current access this cycle.
- pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite, memToReg, regDest, regWrite, aluSrcA  out  1 each  datapath controls.
- aluSrcB  out  2  ALU B mux: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- aluOP  out  2  00 = add, 01 = subtract, 10 = funct decode, 11 = immediate op.
- pcSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding, for debug.
- illegalOp  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- instrCount  out  CNT_WIDTH  count of retired instructions.

## Operation
- States and their outputs. Any output not listed for a state is 0.
- 0 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOP=00, pcSource=00. irWrite and pcWrite are driven equal to memReady. Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- 1 DECODE: aluSrcA=0, aluSrcB=11, aluOP=00. The opcode is latched into an internal opReg. Next state by op:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 or 000101 → BRANCH
  - 000010 → JUMP
  - 001000 or 001010 → IEXEC
  - any other opcode → FETCH, with illegalOp=1 for this cycle.
- 2 MEMADR: aluSrcA=1, aluSrcB=10, aluOP=00. Go to MEMREAD if opReg=lw, else MEMWRITE.
- 3 MEMREAD: memRead=1, iorD=1. Wait for memReady, then go to MEMWB.
- 4 MEMWB: regDest=0, memToReg=1, regWrite=1. Go to FETCH.
- 5 MEMWRITE: memWrite=1, iorD=1. Wait for memReady, then go to FETCH.
- 6 EXEC: aluSrcA=1, aluSrcB=00, aluOP=10. Go to RWB.
- 7 RWB: regDest=1, memToReg=0, regWrite=1. Go to FETCH.
- 8 BRANCH: aluSrcA=1, aluSrcB=00, aluOP=01, pcWriteCond=1, pcSource=01, branchNe=(opReg==000101). Go to FETCH.
- 9 JUMP: pcWrite=1, pcSource=10. Go to FETCH.
- 10 IEXEC: aluSrcA=1, aluSrcB=10, aluOP=11. Go to IWB.
- 11 IWB: regDest=0, memToReg=0, regWrite=1. Go to FETCH.
- Encodings 12–15 are unreachable. If entered, the next state is FETCH and all outputs are 0.
- Outputs are combinational from the state register and opReg only. They never depend combinationally on op, except illegalOp in DECODE. memReady gates only the FETCH enables and the wait transitions.
- instrCount increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, RWB, BRANCH, JUMP or IWB. It wraps modulo 2^CNT_WIDTH and is not incremented on an illegal-opcode return.
- Reset (reset=0, asynchronous) sets state=FETCH, opReg=0 and instrCount=0.
  - While reset is held, pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite and illegalOp are forced to 0.
  - A reset asserted mid-instruction abandons that instruction with no write enables asserted. The abandoned instruction is not counted.

## Timing
- Latency in cycles, with zero wait states: lw 5; sw, R-type, addi and slti 4; beq, bne and j 3; illegal opcode 2.
- Each memReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. The access outputs stay stable while waiting.
- After reset deasserts, the first FETCH cycle begins on the first rising edge.
- op only needs to be valid in DECODE. Later states use opReg.

## Test plan
- Reset, then op=000000 with memReady=1 → states 0,1,6,7,0. regWrite=1 and regDest=1 in state 7 only. instrCount=1.
- op=100011 with memReady held 0 for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. memRead=1 and iorD=1 throughout state 3. instrCount increments once.
- op=000101 → in BRANCH: pcWriteCond=1, branchNe=1, aluOP=01, pcSource=01. op=000100 gives branchNe=0.
- op=111111 → DECODE asserts illegalOp for exactly 1 cycle, then FETCH. instrCount is unchanged.
- Assert reset in MEMWRITE → state=0 asynchronously, memWrite=0 immediately, instrCount=0.
- CNT_WIDTH=4, 16 j instructions → instrCount wraps to 0. With USE_MEM_READY=0 and memReady tied 0, fetch still completes in 1 cycle.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// with optional memory-ready wait states, illegal-opcode flag and retired-instruction counter.
module multicycle_control_unit #(
    parameter int unsigned OP_WIDTH      = 6,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned USE_MEM_READY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [OP_WIDTH-1:0]  op,
    input  logic                 memReady,
    output logic                 pcWrite,
    output logic                 pcWriteCond,
    output logic                 branchNe,
    output logic                 iorD,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 irWrite,
    output logic                 memToReg,
    output logic                 regDest,
    output logic                 regWrite,
    output logic                 aluSrcA,
    output logic [1:0]           aluSrcB,
    output logic [1:0]           aluOP,
    output logic [1:0]           pcSource,
    output logic [3:0]           state,
    output logic                 illegalOp,
    output logic [CNT_WIDTH-1:0] instrCount
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IEXEC    = 4'd10,
        S_IWB      = 4'd11
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_reg;
    logic [5:0] op_lo;
    logic       ready;
    logic       retire;

    assign op_lo = 6'(op);
    // With the handshake disabled every access completes in its first cycle.
    assign ready = memReady | (USE_MEM_READY == 0);
    assign state = state_q;

    // Instructions retire on the return to FETCH from a final state.
    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEMWB, S_MEMWRITE, S_RWB, S_BRANCH, S_JUMP, S_IWB: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            op_reg     <= 6'd0;
            instrCount <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_reg <= op_lo;
            end
            if (retire) begin
                instrCount <= instrCount + CNT_WIDTH'(1);
            end
        end
    end

    // Next state and Moore outputs; write enables are forced low while reset is held.
    always_comb begin
        state_d     = S_FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        branchNe    = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDest     = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOP       = 2'b00;
        pcSource    = 2'b00;
        illegalOp   = 1'b0;

        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = ready;
                pcWrite = ready;
                state_d = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                case (op_lo)
                    OP_RTYPE:         state_d = S_EXEC;
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    default: begin
                        state_d   = S_FETCH;
                        illegalOp = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (op_reg == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                state_d = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                state_d  = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOP   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                regDest  = 1'b1;
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOP       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                branchNe    = (op_reg == OP_BNE);
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_IEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOP   = 2'b11;
                state_d = S_IWB;
            end
            S_IWB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (!reset) begin
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            irWrite     = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            regWrite    = 1'b0;
            illegalOp   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table, random instruction stream
// against a trace-level model, reset-abort and counter-wrap sequences.
module tb_multicycle_control_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       rst_w;
    logic [5:0] op;
    logic [5:0] op_w;
    logic       memReady;
    logic       mem_ready_w;

    logic pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite;
    logic memToReg, regDest, regWrite, aluSrcA, illegalOp;
    logic [1:0]  aluSrcB, aluOP, pcSource;
    logic [3:0]  state;
    logic [15:0] instrCount;

    logic pcWrite_w, pcWriteCond_w, branchNe_w, iorD_w, memRead_w, memWrite_w, irWrite_w;
    logic memToReg_w, regDest_w, regWrite_w, aluSrcA_w, illegalOp_w;
    logic [1:0] aluSrcB_w, aluOP_w, pcSource_w;
    logic [3:0] state_w;
    logic [3:0] instrCount_w;

    multicycle_control_unit dut (
        .clock(clock), .reset(reset), .op(op), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg),
        .regDest(regDest), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluOP(aluOP), .pcSource(pcSource), .state(state), .illegalOp(illegalOp),
        .instrCount(instrCount)
    );

    multicycle_control_unit #(.CNT_WIDTH(4), .USE_MEM_READY(0)) dut_w (
        .clock(clock), .reset(rst_w), .op(op_w), .memReady(mem_ready_w),
        .pcWrite(pcWrite_w), .pcWriteCond(pcWriteCond_w), .branchNe(branchNe_w), .iorD(iorD_w),
        .memRead(memRead_w), .memWrite(memWrite_w), .irWrite(irWrite_w), .memToReg(memToReg_w),
        .regDest(regDest_w), .regWrite(regWrite_w), .aluSrcA(aluSrcA_w), .aluSrcB(aluSrcB_w),
        .aluOP(aluOP_w), .pcSource(pcSource_w), .state(state_w), .illegalOp(illegalOp_w),
        .instrCount(instrCount_w)
    );

    logic [17:0] act;
    assign act = {pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite,
                  memToReg, regDest, regWrite, aluSrcA, aluSrcB, aluOP, pcSource, illegalOp};

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    typedef struct {
        logic [5:0] opc;
        int         wf;
        int         wm;
        int         lat;
        int         inc;
        int         ill;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] o);
        return o inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h23, 6'h2b};
    endfunction

    // Expected control word for a given state, following the per-state output table.
    function automatic logic [17:0] exp_ctl(input int s, input logic mr,
                                            input logic [5:0] op_now, input logic [5:0] opr);
        logic pw, pwc, bne, iord, mrd, mwr, irw, m2r, rd, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, bne, iord, mrd, mwr, irw, m2r, rd, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
            1:  begin asb = 2'b11; ill = !is_legal(op_now); end
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; bne = (opr == 6'h05); end
            9:  begin pw = 1'b1; psrc = 2'b10; end
            10: begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
            11: begin rw = 1'b1; end
            default: ;
        endcase
        return {pw, pwc, bne, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
    endfunction

    // Runs one instruction from a FETCH cycle; the expected state trace comes from the
    // instruction class plus the requested fetch and memory wait counts.
    task automatic run_instr(input logic [5:0] opc, input int wf, input int wm,
                             output int busy, output int ills);
        int q[$];
        int fw;
        int mw;
        int s;
        logic mr;
        for (int i = 0; i < wf; i++) q.push_back(0);
        q.push_back(0);
        q.push_back(1);
        case (opc)
            6'h00: begin q.push_back(6); q.push_back(7); end
            6'h23: begin q.push_back(2); for (int i = 0; i <= wm; i++) q.push_back(3); q.push_back(4); end
            6'h2b: begin q.push_back(2); for (int i = 0; i <= wm; i++) q.push_back(5); end
            6'h04, 6'h05: q.push_back(8);
            6'h02: q.push_back(9);
            6'h08, 6'h0a: begin q.push_back(10); q.push_back(11); end
            default: ;
        endcase
        busy = 0;
        ills = 0;
        fw = wf;
        mw = wm;
        foreach (q[i]) begin
            s = q[i];
            if (s == 0) begin
                mr = (fw == 0);
                if (fw > 0) fw--;
            end else if (s == 3 || s == 5) begin
                mr = (mw == 0);
                if (mw > 0) mw--;
            end else begin
                mr = 1'($urandom);
            end
            memReady = mr;
            op = (s == 1) ? opc : 6'($urandom);
            #1;
            chk("state", 32'(state), 32'(s));
            chk("ctl", 32'(act), 32'(exp_ctl(s, mr, op, opc)));
            if (state != 4'd0) busy++;
            if (illegalOp) ills++;
            @(posedge clock);
            #1;
        end
        chk("return_fetch", 32'(state), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy;
        int ills;
        int sel;
        logic [5:0] ropc;
        logic [5:0] legal_ops [8];
        legal_ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0a};

        vecs[0]  = '{6'h00, 0, 0, 4, 1, 0};
        vecs[1]  = '{6'h23, 0, 2, 7, 1, 0};
        vecs[2]  = '{6'h2b, 1, 1, 5, 1, 0};
        vecs[3]  = '{6'h04, 0, 0, 3, 1, 0};
        vecs[4]  = '{6'h05, 0, 0, 3, 1, 0};
        vecs[5]  = '{6'h02, 0, 0, 3, 1, 0};
        vecs[6]  = '{6'h08, 0, 0, 4, 1, 0};
        vecs[7]  = '{6'h0a, 2, 0, 4, 1, 0};
        vecs[8]  = '{6'h3f, 0, 0, 2, 0, 1};
        vecs[9]  = '{6'h03, 0, 0, 2, 0, 1};
        vecs[10] = '{6'h23, 0, 0, 5, 1, 0};

        reset = 1'b0;
        rst_w = 1'b0;
        memReady = 1'b1;
        mem_ready_w = 1'b0;
        op = 6'h00;
        op_w = 6'h02;

        // Held reset: FETCH state, zero count, enables forced low.
        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(instrCount), 32'd0);
        chk("rst_memread", 32'(memRead), 32'd0);
        chk("rst_irwrite", 32'(irWrite), 32'd0);
        chk("rst_pcwrite", 32'(pcWrite), 32'd0);
        chk("rst_w_state", 32'(state_w), 32'd0);
        chk("rst_w_count", 32'(instrCount_w), 32'd0);
        #20;
        reset = 1'b1;
        exp_cnt = 0;

        foreach (vecs[i]) begin
            run_instr(vecs[i].opc, vecs[i].wf, vecs[i].wm, busy, ills);
            exp_cnt += vecs[i].inc;
            chk("vec_latency", 32'(busy), 32'(vecs[i].lat - 1));
            chk("vec_illegal_pulses", 32'(ills), 32'(vecs[i].ill));
            chk("vec_count", 32'(instrCount), 32'(16'(exp_cnt)));
        end

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 8);
            if (sel < 8) begin
                ropc = legal_ops[sel];
            end else begin
                ropc = 6'($urandom);
                while (is_legal(ropc)) ropc = 6'($urandom);
            end
            run_instr(ropc, $urandom_range(0, 2), $urandom_range(0, 2), busy, ills);
            if (is_legal(ropc)) exp_cnt++;
            chk("rand_illegal_pulses", 32'(ills), 32'(!is_legal(ropc)));
            chk("rand_count", 32'(instrCount), 32'(16'(exp_cnt)));
        end

        // Reset asserted while sw waits in MEMWRITE.
        memReady = 1'b1;
        op = 6'h2b;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        memReady = 1'b0;
        #1;
        chk("abort_pre_state", 32'(state), 32'd5);
        chk("abort_pre_memwrite", 32'(memWrite), 32'd1);
        #1;
        memReady = 1'b1;
        reset = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_memwrite", 32'(memWrite), 32'd0);
        chk("abort_memread", 32'(memRead), 32'd0);
        chk("abort_irwrite", 32'(irWrite), 32'd0);
        chk("abort_count", 32'(instrCount), 32'd0);
        @(posedge clock); #1;
        chk("abort_hold_state", 32'(state), 32'd0);
        chk("abort_hold_pcwrite", 32'(pcWrite), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        exp_cnt = 0;
        run_instr(6'h00, 0, 0, busy, ills);
        chk("after_abort_count", 32'(instrCount), 32'd1);

        // Narrow counter wraps; memReady tied low is ignored with the handshake disabled.
        @(negedge clock);
        rst_w = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("wrap_fetch_state", 32'(state_w), 32'd0);
            chk("wrap_fetch_irwrite", 32'(irWrite_w), 32'd1);
            @(posedge clock); #1;
            chk("wrap_decode_state", 32'(state_w), 32'd1);
            @(posedge clock); #1;
            chk("wrap_jump_state", 32'(state_w), 32'd9);
            chk("wrap_jump_pcwrite", 32'(pcWrite_w), 32'd1);
            @(posedge clock);
            #1;
            chk("wrap_count", 32'(instrCount_w), 32'((k + 1) % 16));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
